bitty_control_unit: RTL and testbench
=====================================

Name: bitty_control_unit

Overview:
- Multi-cycle sequencer for the bitty processor.
- Each instruction walks through these steps:
  - pulses the fetch unit's enable and captures the returned 16-bit instruction;
  - decodes it;
  - steers the operand mux and the S, C and result-register enables;
  - supplies the ALU opcode and writes the result back to the destination register.
- Sits between the fetch unit and the datapath (register file, operand mux, ALU). It owns all datapath enables.

Parameters:
- IMM_SEL, 8: operand-mux select code that routes the immediate (imm_out) onto the bus.
- CNT_W, 16: width of the retired-instruction counter.
- HALT_WORD, 16'hFFFF: instruction encoding that halts the processor.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- run  in  1  level; high = keep executing instructions
- instruction  in  16  fetch unit output; valid the cycle after fetch_en is high
- fetch_en  out  1  enable to fetch unit (advances PC, loads instruction)
- mux_sel  out  4  operand-mux select; 0-7 = register index, IMM_SEL = immediate
- imm_out  out  8  immediate operand
- en_s  out  1  load S (first operand) register
- en_c  out  1  load C (second operand) register
- alu_sel  out  3  ALU opcode
- en_i  out  8  one-hot register-file write enables
- busy  out  1  high in any state except IDLE and HALT
- done  out  1  one-cycle pulse when an instruction retires
- halted  out  1  high while in HALT
- instr_count  out  CNT_W  retired-instruction count

Behaviour:
- Reset: synchronous and active-high, with priority over everything else; it takes effect at any state, including mid-instruction.
  - State goes to IDLE; ir and instr_count go to 0.
  - All outputs go to 0: fetch_en, en_s, en_c, en_i, done, busy, halted, mux_sel, imm_out, alu_sel.
- Decode fields of the internal 16-bit instruction register ir:
  - rx = ir[15:13], ry = ir[12:10], imm = ir[12:5], alu_sel = ir[4:2], fmt = ir[1:0].
  - fmt 00 = reg-reg; fmt 01 = immediate; fmt 10/11 = NOP (any non-HALT_WORD value).
- All outputs are registered: they are decoded from the next-state and ir and held for the whole state. Enables are 0 in every state not listed below.
- State machine:
  - IDLE: run=1 -> FETCH, else stay.
  - FETCH: fetch_en=1 for exactly one cycle -> DECODE.
  - DECODE: ir <= instruction.
    - instruction == HALT_WORD -> HALT.
    - fmt 10/11 -> DONE.
    - otherwise -> LOAD_S.
  - LOAD_S: mux_sel={0,rx}, en_s=1 -> LOAD_C.
  - LOAD_C: en_c=1 -> WRITE.
    - fmt 00: mux_sel={0,ry}.
    - fmt 01: mux_sel=IMM_SEL, imm_out=imm.
  - WRITE: alu_sel=ir[4:2], en_i=1<<rx -> DONE.
  - DONE: done=1 and instr_count<=instr_count+1 (wraps modulo 2^CNT_W).
    - run=1 -> FETCH; run=0 -> IDLE.
  - HALT: halted=1; all enables 0; ignores run; left only by reset. HALT_WORD does not increment instr_count.
- Latency:
  - run sampled high in IDLE at edge k -> fetch_en high in cycle k+1.
  - ALU/reg-reg instruction: 6 cycles FETCH->DONE.
  - NOP: 3 cycles (FETCH, DECODE, DONE).
- Back-to-back execution: with run held high, the next FETCH immediately follows DONE, with no idle cycle.
- run dropping mid-instruction: has no effect until DONE; the current instruction always completes.
- Single-step: a one-cycle run pulse in IDLE executes exactly one instruction.
- en_i: exactly one bit high, and only in WRITE. en_s/en_c are never high in the same cycle.

Test Plan:
- Reset, then run=1 with instruction=16'h2400 (rx=1, ry=1, fmt00, alu 0) -> cycle sequence:
  - fetch_en pulses 1 cycle;
  - LOAD_S: mux_sel=1, en_s=1;
  - LOAD_C: mux_sel=1, en_c=1;
  - WRITE: en_i=8'h02, alu_sel=0;
  - done pulses in cycle 6; instr_count=1.
- Immediate: instruction=16'hE1E5 (rx=7, imm=8'h0F, alu 1, fmt01) -> LOAD_C shows mux_sel=8, imm_out=8'h0F; WRITE shows en_i=8'h80, alu_sel=1.
- run held high over 3 instructions -> fetch_en every 6 cycles, no gap after DONE; instr_count=3.
- NOP 16'h0002 then HALT_WORD 16'hFFFF:
  - NOP: done after 3 cycles, count+1, no en_s/en_c/en_i activity.
  - HALT_WORD: halted=1, busy=0, count unchanged, run toggling has no effect.
- Assert reset during LOAD_C -> next cycle state IDLE, all enables 0, instr_count=0. With run=1 after release, FETCH follows.
- Preload instr_count path by running 2^CNT_W NOPs (or use CNT_W=4 with 16 NOPs) -> count wraps to 0.

Source files
------------

// File: rtl/bitty_control_unit.sv
// Multi-cycle sequencer for the bitty processor: fetch, decode, operand load,
// ALU write-back and retire, with a sticky HALT state left only by reset.
module bitty_control_unit #(
   parameter logic [3:0]  IMM_SEL   = 4'd8,
   parameter int          CNT_W     = 16,
   parameter logic [15:0] HALT_WORD = 16'hFFFF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   input  logic [15:0]      instruction,
   output logic             fetch_en,
   output logic [3:0]       mux_sel,
   output logic [7:0]       imm_out,
   output logic             en_s,
   output logic             en_c,
   output logic [2:0]       alu_sel,
   output logic [7:0]       en_i,
   output logic             busy,
   output logic             done,
   output logic             halted,
   output logic [CNT_W-1:0] instr_count
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_LOAD_S, S_LOAD_C, S_WRITE, S_DONE, S_HALT
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] ir_q, ir_d;

   logic [2:0]  rx_d, ry_d, alu_d;
   logic [7:0]  imm_d;
   logic [1:0]  fmt_d;

   assign rx_d  = ir_d[15:13];
   assign ry_d  = ir_d[12:10];
   assign imm_d = ir_d[12:5];
   assign alu_d = ir_d[4:2];
   assign fmt_d = ir_d[1:0];

   // NOTE: every variable written here gets a default first, so no latch is inferred.
   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      unique case (state_q)
         S_IDLE:   if (run) state_d = S_FETCH;
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            ir_d = instruction;
            if (instruction == HALT_WORD) state_d = S_HALT;
            else if (instruction[1])      state_d = S_DONE;
            else                          state_d = S_LOAD_S;
         end
         S_LOAD_S: state_d = S_LOAD_C;
         S_LOAD_C: state_d = S_WRITE;
         S_WRITE:  state_d = S_DONE;
         S_DONE:   state_d = run ? S_FETCH : S_IDLE;
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_IDLE;
      endcase
   end

   // NOTE: outputs are decoded from state_d so the registered value lines up
   // with the state it belongs to and is held for that whole cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         ir_q        <= '0;
         instr_count <= '0;
         fetch_en    <= 1'b0;
         mux_sel     <= '0;
         imm_out     <= '0;
         en_s        <= 1'b0;
         en_c        <= 1'b0;
         alu_sel     <= '0;
         en_i        <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         halted      <= 1'b0;
      end else begin
         state_q  <= state_d;
         ir_q     <= ir_d;
         fetch_en <= 1'b0;
         mux_sel  <= '0;
         imm_out  <= '0;
         en_s     <= 1'b0;
         en_c     <= 1'b0;
         alu_sel  <= '0;
         en_i     <= '0;
         done     <= 1'b0;
         busy     <= (state_d != S_IDLE) && (state_d != S_HALT);
         halted   <= (state_d == S_HALT);
         unique case (state_d)
            S_FETCH:  fetch_en <= 1'b1;
            S_LOAD_S: begin
               mux_sel <= {1'b0, rx_d};
               en_s    <= 1'b1;
            end
            S_LOAD_C: begin
               en_c <= 1'b1;
               if (fmt_d == 2'b01) begin
                  mux_sel <= IMM_SEL;
                  imm_out <= imm_d;
               end else begin
                  mux_sel <= {1'b0, ry_d};
               end
            end
            S_WRITE: begin
               alu_sel <= alu_d;
               en_i    <= 8'b1 << rx_d;
            end
            S_DONE: begin
               done        <= 1'b1;
               instr_count <= instr_count + CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bitty_control_unit.sv
// Self-checking bench for bitty_control_unit: per-cycle output traces are
// queued from a vector table and compared cycle by cycle on the falling edge.
module tb_bitty_control_unit;

   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             reset, run;
   logic [15:0]      instruction;
   logic             fetch_en, en_s, en_c, busy, done, halted;
   logic [3:0]       mux_sel;
   logic [7:0]       imm_out, en_i;
   logic [2:0]       alu_sel;
   logic [CNT_W-1:0] instr_count;

   bitty_control_unit #(.IMM_SEL(4'd8), .CNT_W(CNT_W), .HALT_WORD(16'hFFFF)) dut (
      .clk(clk), .reset(reset), .run(run), .instruction(instruction),
      .fetch_en(fetch_en), .mux_sel(mux_sel), .imm_out(imm_out),
      .en_s(en_s), .en_c(en_c), .alu_sel(alu_sel), .en_i(en_i),
      .busy(busy), .done(done), .halted(halted), .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       fetch_en;
      logic [3:0] mux_sel;
      logic [7:0] imm_out;
      logic       en_s;
      logic       en_c;
      logic [2:0] alu_sel;
      logic [7:0] en_i;
      logic       busy;
      logic       done;
      logic       halted;
   } outs_t;

   typedef struct {
      string       name;
      logic [15:0] instr;
      logic        nop;
      logic [3:0]  mux_s;
      logic [3:0]  mux_c;
      logic [7:0]  imm;
      logic [2:0]  alu;
      logic [7:0]  en_i;
   } vec_t;

   outs_t      sb_q[$];
   vec_t       vecs[6];
   vec_t       nop_v;
   int         total = 0;
   int         bad   = 0;
   logic [3:0] exp_count;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic void push_instr(input vec_t v);
      outs_t o;
      o = '0; o.fetch_en = 1'b1; o.busy = 1'b1; sb_q.push_back(o);
      o = '0; o.busy = 1'b1; sb_q.push_back(o);
      if (!v.nop) begin
         o = '0; o.busy = 1'b1; o.mux_sel = v.mux_s; o.en_s = 1'b1; sb_q.push_back(o);
         o = '0; o.busy = 1'b1; o.mux_sel = v.mux_c; o.imm_out = v.imm; o.en_c = 1'b1;
         sb_q.push_back(o);
         o = '0; o.busy = 1'b1; o.alu_sel = v.alu; o.en_i = v.en_i; sb_q.push_back(o);
      end
      o = '0; o.busy = 1'b1; o.done = 1'b1; sb_q.push_back(o);
   endfunction

   // Compares one queued expectation per cycle; run drops after entry drop_at.
   task automatic drain(input string name, input int drop_at);
      outs_t e, a;
      int    i;
      i = 0;
      while (sb_q.size() > 0) begin
         @(negedge clk);
         e = sb_q.pop_front();
         a = {fetch_en, mux_sel, imm_out, en_s, en_c, alu_sel, en_i, busy, done, halted};
         check($sformatf("%s[%0d]", name, i), 32'(a), 32'(e));
         if (i == drop_at) run = 1'b0;
         i++;
         @(posedge clk); #1;
      end
   endtask

   task automatic step(input vec_t v);
      instruction = v.instr;
      run = 1'b1;
      @(posedge clk); #1;
      run = 1'b0;
      push_instr(v);
      sb_q.push_back('0);
      drain(v.name, -1);
      exp_count = exp_count + 4'd1;
      check({v.name, "_count"}, 32'(instr_count), 32'(exp_count));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      exp_count = '0;
      sb_q.push_back('0);
      drain("after_reset", -1);
      check("reset_count", 32'(instr_count), 32'(exp_count));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      outs_t o;
      vecs[0] = '{"rr_2400", 16'h2400, 1'b0, 4'd1, 4'd1, 8'h00, 3'd0, 8'h02};
      vecs[1] = '{"imm_E1E5", 16'hE1E5, 1'b0, 4'd7, 4'd8, 8'h0F, 3'd1, 8'h80};
      vecs[2] = '{"nop_0002", 16'h0002, 1'b1, 4'd0, 4'd0, 8'h00, 3'd0, 8'h00};
      vecs[3] = '{"rr_7418", 16'h7418, 1'b0, 4'd3, 4'd5, 8'h00, 3'd6, 8'h08};
      vecs[4] = '{"imm_14BD", 16'h14BD, 1'b0, 4'd0, 4'd8, 8'hA5, 3'd7, 8'h01};
      vecs[5] = '{"nop_1233", 16'h1233, 1'b1, 4'd0, 4'd0, 8'h00, 3'd0, 8'h00};
      nop_v   = vecs[2];

      reset = 1'b1; run = 1'b0; instruction = '0; exp_count = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_outs", 32'({fetch_en, mux_sel, imm_out, en_s, en_c, alu_sel, en_i,
                               busy, done, halted}), 32'(0));
      check("reset_cnt", 32'(instr_count), 32'(0));
      @(posedge clk); #1;
      reset = 1'b0;

      for (int k = 0; k < 6; k++) step(vecs[k]);

      // Three back-to-back instructions; run drops during the third one's decode.
      instruction = 16'h2400;
      run = 1'b1;
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) push_instr(vecs[0]);
      sb_q.push_back('0);
      drain("b2b", 13);
      exp_count = exp_count + 4'd3;
      check("b2b_count", 32'(instr_count), 32'(exp_count));

      // HALT_WORD: sticky halt, run ignored, count unchanged.
      instruction = 16'hFFFF;
      run = 1'b1;
      @(posedge clk); #1;
      run = 1'b0;
      o = '0; o.fetch_en = 1'b1; o.busy = 1'b1; sb_q.push_back(o);
      o = '0; o.busy = 1'b1; sb_q.push_back(o);
      drain("halt_entry", -1);
      for (int k = 0; k < 6; k++) begin
         run = (k % 2 == 0);
         o = '0; o.halted = 1'b1; sb_q.push_back(o);
         drain("halt_hold", -1);
      end
      check("halt_count", 32'(instr_count), 32'(exp_count));
      run = 1'b0;
      do_reset();

      // Reset asserted while in LOAD_C, then run resumes from IDLE.
      instruction = 16'h2400;
      step(vecs[0]);
      instruction = 16'h2400;
      run = 1'b1;
      @(posedge clk); #1;
      run = 1'b0;
      push_instr(vecs[0]);
      while (sb_q.size() > 3) void'(sb_q.pop_back());
      drain("mid_pre", -1);
      reset = 1'b1;
      run = 1'b1;
      o = '0; o.busy = 1'b1; o.mux_sel = 4'd1; o.en_c = 1'b1; sb_q.push_back(o);
      drain("mid_loadc", -1);
      reset = 1'b0;
      exp_count = '0;
      sb_q.push_back('0);
      push_instr(vecs[0]);
      sb_q.push_back('0);
      @(negedge clk);
      check("mid_reset_count", 32'(instr_count), 32'(exp_count));
      @(posedge clk); #1;
      void'(sb_q.pop_front());
      push_instr(vecs[0]);
      while (sb_q.size() > 0) void'(sb_q.pop_back());
      push_instr(vecs[0]);
      sb_q.push_back('0);
      drain("mid_resume", 0);
      exp_count = exp_count + 4'd1;
      check("mid_resume_count", 32'(instr_count), 32'(exp_count));

      // Counter wrap: 16 NOPs on a 4-bit counter return it to zero.
      do_reset();
      for (int k = 0; k < 16; k++) step(nop_v);
      check("wrap_zero", 32'(instr_count), 32'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
